// File: rtl/pulse_gen_pkg.sv
// Shared types and width helper for the multi-channel pulse generator.
package pulse_gen_pkg;

  typedef enum logic [1:0] {
    MODE_RISE   = 2'b00,
    MODE_FALL   = 2'b01,
    MODE_BOTH   = 2'b10,
    MODE_REPEAT = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PULSE = 2'b01,
    ST_HOLD  = 2'b10
  } state_e;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pulse_gen_multi_if.sv
// Button-side inputs and strobe outputs of the pulse generator.
interface pulse_gen_multi_if #(
  parameter int unsigned N_CH = 4
);
  logic [N_CH-1:0] btn;
  logic            en;
  logic [1:0]      mode;
  logic [N_CH-1:0] pulso;
  logic [N_CH-1:0] level;

  modport master (output btn, en, mode, input pulso, level);
  modport slave  (input btn, en, mode, output pulso, level);
endinterface

// File: rtl/pulse_gen_channel.sv
// One channel: 2-flop synchroniser, debouncer, and pulse/auto-repeat FSM.
module pulse_gen_channel
  import pulse_gen_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned PULSE_LEN       = 2,
  parameter int unsigned REPEAT_PERIOD   = 8
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  btn,
  input  logic  en,
  input  mode_e mode,
  output logic  pulso,
  output logic  level
);

  localparam int unsigned DB_W = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned P_W  = cnt_width(PULSE_LEN);
  localparam int unsigned R_W  = cnt_width(REPEAT_PERIOD);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [P_W-1:0]  P_LAST  = P_W'(PULSE_LEN - 1);
  localparam logic [R_W-1:0]  R_LAST  = R_W'(REPEAT_PERIOD - 1);

  logic [1:0]      sync_q;
  logic            sync;
  logic            stable;
  logic            stable_d;
  logic [DB_W-1:0] db_cnt;
  logic            rise;
  logic            fall;
  logic            trig;

  state_e          state;
  state_e          state_n;
  logic [P_W-1:0]  pcnt;
  logic [P_W-1:0]  pcnt_n;
  logic [R_W-1:0]  rcnt;
  logic [R_W-1:0]  rcnt_n;

  assign sync = sync_q[1];

  // Synchroniser and debouncer; stable only follows sync after DEBOUNCE_CYCLES agreeing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= 2'b00;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      db_cnt   <= '0;
    end else begin
      sync_q   <= {sync_q[0], btn};
      stable_d <= stable;
      if (sync == stable) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        stable <= sync;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  assign rise  = stable & ~stable_d;
  assign fall  = ~stable & stable_d;
  assign level = stable;

  always_comb begin
    trig = 1'b0;
    case (mode)
      MODE_RISE, MODE_REPEAT: trig = rise;
      MODE_FALL:              trig = fall;
      MODE_BOTH:              trig = rise | fall;
      default:                trig = 1'b0;
    endcase
    trig = trig & en;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      pcnt  <= '0;
      rcnt  <= '0;
      pulso <= 1'b0;
    end else begin
      state <= state_n;
      pcnt  <= pcnt_n;
      rcnt  <= rcnt_n;
      pulso <= (state_n == ST_PULSE);
    end
  end

  // Next-state: triggers outside IDLE are dropped; HOLD waits at expiry while en is low.
  always_comb begin
    state_n = state;
    pcnt_n  = pcnt;
    rcnt_n  = rcnt;
    case (state)
      ST_IDLE: begin
        if (trig) begin
          state_n = ST_PULSE;
          pcnt_n  = '0;
          rcnt_n  = '0;
        end
      end
      ST_PULSE: begin
        pcnt_n = pcnt + P_W'(1);
        rcnt_n = rcnt + R_W'(1);
        if (pcnt == P_LAST) begin
          state_n = ((mode == MODE_REPEAT) && stable) ? ST_HOLD : ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (!stable || (mode != MODE_REPEAT)) begin
          state_n = ST_IDLE;
        end else if (rcnt == R_LAST) begin
          if (en) begin
            state_n = ST_PULSE;
            pcnt_n  = '0;
            rcnt_n  = '0;
          end
        end else begin
          rcnt_n = rcnt + R_W'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/pulse_gen_multi.sv
// N_CH independent debounced pulse generators sharing enable and edge mode.
module pulse_gen_multi
  import pulse_gen_pkg::*;
#(
  parameter int unsigned N_CH            = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned PULSE_LEN       = 2,
  parameter int unsigned REPEAT_PERIOD   = 8
) (
  input  logic              clk,
  input  logic              rst,
  pulse_gen_multi_if.slave  bus
);

  logic [N_CH-1:0] pulso_v;
  logic [N_CH-1:0] level_v;
  mode_e           mode;

  assign mode      = mode_e'(bus.mode);
  assign bus.pulso = pulso_v;
  assign bus.level = level_v;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pulse_gen_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .PULSE_LEN       (PULSE_LEN),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .btn   (bus.btn[i]),
      .en    (bus.en),
      .mode  (mode),
      .pulso (pulso_v[i]),
      .level (level_v[i])
    );
  end

endmodule

// File: tb/tb_pulse_gen_multi.sv
// Directed bench: run-length waveform table for pulso/level plus an async-reset sequence.
module tb_pulse_gen_multi;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pulse_gen_multi_if #(.N_CH(4)) bus ();

  pulse_gen_multi #(
    .N_CH            (4),
    .DEBOUNCE_CYCLES (4),
    .PULSE_LEN       (2),
    .REPEAT_PERIOD   (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Inputs held for n edges; pulso/level must equal the given values after each of them.
  typedef struct {
    logic [3:0] btn;
    logic       en;
    logic [1:0] mode;
    int         n;
    logic [3:0] pulso;
    logic [3:0] level;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  task automatic add(input logic [3:0] b, input logic e, input logic [1:0] m, input int n,
                     input logic [3:0] p, input logic [3:0] l);
    vec_t v;
    v.btn = b; v.en = e; v.mode = m; v.n = n; v.pulso = p; v.level = l;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] p, input logic [3:0] l);
    total++;
    if (bus.pulso !== p || bus.level !== l) begin
      bad++;
      $display("FAIL %s @%0t: pulso=%b level=%b, want pulso=%b level=%b",
               name, $time, bus.pulso, bus.level, p, l);
    end
  endtask

  initial begin
    // 1: rising edge on ch0, pulse after edges 6,7, level from edge 5
    add(4'h1, 1, 2'b00, 5, 4'h0, 4'h0);
    add(4'h1, 1, 2'b00, 1, 4'h0, 4'h1);
    add(4'h1, 1, 2'b00, 2, 4'h1, 4'h1);
    add(4'h1, 1, 2'b00, 4, 4'h0, 4'h1);
    add(4'h0, 1, 2'b00, 5, 4'h0, 4'h1);
    add(4'h0, 1, 2'b00, 3, 4'h0, 4'h0);
    // 2: 3-cycle glitch on ch1 is rejected, 6-cycle press gives one pulse
    add(4'h2, 1, 2'b00, 3, 4'h0, 4'h0);
    add(4'h0, 1, 2'b00, 8, 4'h0, 4'h0);
    add(4'h2, 1, 2'b00, 5, 4'h0, 4'h0);
    add(4'h2, 1, 2'b00, 1, 4'h0, 4'h2);
    add(4'h0, 1, 2'b00, 2, 4'h2, 4'h2);
    add(4'h0, 1, 2'b00, 3, 4'h0, 4'h2);
    add(4'h0, 1, 2'b00, 4, 4'h0, 4'h0);
    // 3: both edges on ch2, pulses at 6 and 26
    add(4'h4, 1, 2'b10, 5, 4'h0, 4'h0);
    add(4'h4, 1, 2'b10, 1, 4'h0, 4'h4);
    add(4'h4, 1, 2'b10, 2, 4'h4, 4'h4);
    add(4'h4, 1, 2'b10, 12, 4'h0, 4'h4);
    add(4'h0, 1, 2'b10, 5, 4'h0, 4'h4);
    add(4'h0, 1, 2'b10, 1, 4'h0, 4'h0);
    add(4'h0, 1, 2'b10, 2, 4'h4, 4'h0);
    add(4'h0, 1, 2'b10, 4, 4'h0, 4'h0);
    // 4: auto-repeat on ch3, starts at 6,14,22,30,38, nothing after release
    add(4'h8, 1, 2'b11, 5, 4'h0, 4'h0);
    add(4'h8, 1, 2'b11, 1, 4'h0, 4'h8);
    for (int k = 0; k < 4; k++) begin
      add(4'h8, 1, 2'b11, 2, 4'h8, 4'h8);
      add(4'h8, 1, 2'b11, 6, 4'h0, 4'h8);
    end
    add(4'h8, 1, 2'b11, 2, 4'h8, 4'h8);
    add(4'h0, 1, 2'b11, 5, 4'h0, 4'h8);
    add(4'h0, 1, 2'b11, 8, 4'h0, 4'h0);
    // 5a: en low across the rise swallows the pulse for good
    add(4'h1, 0, 2'b00, 5, 4'h0, 4'h0);
    add(4'h1, 0, 2'b00, 1, 4'h0, 4'h1);
    add(4'h1, 0, 2'b00, 4, 4'h0, 4'h1);
    add(4'h1, 1, 2'b00, 3, 4'h0, 4'h1);
    add(4'h0, 1, 2'b00, 5, 4'h0, 4'h1);
    add(4'h0, 1, 2'b00, 3, 4'h0, 4'h0);
    // 5b: en drops and button bounces mid-pulse; pulse still 2 cycles, no extra
    add(4'h1, 1, 2'b00, 5, 4'h0, 4'h0);
    add(4'h1, 1, 2'b00, 1, 4'h0, 4'h1);
    add(4'h1, 1, 2'b00, 1, 4'h1, 4'h1);
    add(4'h0, 0, 2'b00, 1, 4'h1, 4'h1);
    add(4'h1, 0, 2'b00, 3, 4'h0, 4'h1);
    add(4'h1, 1, 2'b00, 4, 4'h0, 4'h1);
    add(4'h0, 1, 2'b00, 5, 4'h0, 4'h1);
    add(4'h0, 1, 2'b00, 3, 4'h0, 4'h0);
    // 5c: leaving repeat mode while in HOLD returns to idle; re-entering does not resume
    add(4'h2, 1, 2'b11, 5, 4'h0, 4'h0);
    add(4'h2, 1, 2'b11, 1, 4'h0, 4'h2);
    add(4'h2, 1, 2'b11, 2, 4'h2, 4'h2);
    add(4'h2, 1, 2'b11, 2, 4'h0, 4'h2);
    add(4'h2, 1, 2'b00, 2, 4'h0, 4'h2);
    add(4'h2, 1, 2'b11, 8, 4'h0, 4'h2);
    add(4'h0, 1, 2'b11, 5, 4'h0, 4'h2);
    add(4'h0, 1, 2'b11, 3, 4'h0, 4'h0);
    // 5d: en low at repeat expiry stalls; restart the edge en returns
    add(4'h4, 1, 2'b11, 5, 4'h0, 4'h0);
    add(4'h4, 1, 2'b11, 1, 4'h0, 4'h4);
    add(4'h4, 1, 2'b11, 2, 4'h4, 4'h4);
    add(4'h4, 1, 2'b11, 5, 4'h0, 4'h4);
    add(4'h4, 0, 2'b11, 4, 4'h0, 4'h4);
    add(4'h4, 1, 2'b11, 2, 4'h4, 4'h4);
    add(4'h4, 1, 2'b11, 6, 4'h0, 4'h4);
    add(4'h4, 1, 2'b11, 2, 4'h4, 4'h4);
    add(4'h0, 1, 2'b11, 5, 4'h0, 4'h4);
    add(4'h0, 1, 2'b11, 3, 4'h0, 4'h0);

    rst      = 1'b1;
    bus.btn  = 4'h0;
    bus.en   = 1'b1;
    bus.mode = 2'b00;
    #2;
    check("reset_state", 4'h0, 4'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_hold", 4'h0, 4'h0);
    rst = 1'b0;

    foreach (vecs[k]) begin
      bus.btn  = vecs[k].btn;
      bus.en   = vecs[k].en;
      bus.mode = vecs[k].mode;
      for (int c = 0; c < vecs[k].n; c++) begin
        @(posedge clk);
        #1;
        check($sformatf("vec%0d.%0d", k, c), vecs[k].pulso, vecs[k].level);
      end
    end

    // 6: all channels together, async reset mid-pulse, then re-debounce from zero
    bus.btn  = 4'hF;
    bus.en   = 1'b1;
    bus.mode = 2'b00;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("all_pre%0d", c), 4'h0, (c == 5) ? 4'hF : 4'h0);
    end
    @(posedge clk);
    #1;
    check("all_pulse", 4'hF, 4'hF);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst", 4'h0, 4'h0);
    @(posedge clk);
    #1;
    check("rst_held", 4'h0, 4'h0);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("post_rst%0d", c), (c == 6 || c == 7) ? 4'hF : 4'h0,
            (c >= 5) ? 4'hF : 4'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
